// File: rtl/ckpt_latency_monitor.sv
// Checkpoint-bus latency monitor: debounces tagged codes, times N segments
// between an arm and pass code, and latches timeout/sequencing errors.
module ckpt_latency_monitor #(
   parameter int unsigned CODE_W      = 16,
   parameter logic [7:0]  TAG         = 8'hAB,
   parameter logic [7:0]  ARM_IDX     = 8'h40,
   parameter logic [7:0]  PASS_IDX    = 8'h51,
   parameter int unsigned N_SEG       = 3,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned STABLE_CYC  = 2,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              clr_i,
   input  logic [CODE_W-1:0] code_i,
   input  logic [3:0]        rd_idx_i,
   output logic [CNT_W-1:0]  rd_lat_o,
   output logic [N_SEG-1:0]  lat_valid_o,
   output logic [3:0]        seg_o,
   output logic              acc_o,
   output logic              done_o,
   output logic              fail_o,
   output logic [1:0]        err_o
);

   localparam int unsigned   STAB_W   = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);
   localparam int unsigned   TO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam int unsigned   IDX_W    = (N_SEG > 1) ? $clog2(N_SEG) : 1;
   localparam logic [4:0]    NSEG_5   = 5'(N_SEG);
   localparam logic [3:0]    SEG_LAST = 4'(N_SEG - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_WAIT_PASS,
      S_DONE,
      S_FAIL
   } state_t;

   logic              w_clear;
   logic [CODE_W-1:0] r_cand;
   logic [CODE_W-1:0] r_acc_code;
   logic [STAB_W-1:0] r_stab;
   logic              r_acc;
   logic              w_acc;
   logic              w_tagged;
   logic [7:0]        w_lo;
   logic              w_is_arm;
   logic              w_is_pass;
   logic              w_is_end;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_lat_next;
   logic [TO_W-1:0]   r_tcnt;
   logic [CNT_W-1:0]  r_lat [N_SEG];
   logic [N_SEG-1:0]  r_lat_valid;
   logic [3:0]        r_seg;
   logic              r_done;
   logic              r_fail;
   logic [1:0]        r_err;
   logic [CNT_W-1:0]  r_rd_lat;
   logic              w_active;
   logic              w_timeout;

   assign w_clear    = wb_rst_i | clr_i;
   assign w_acc      = (r_stab == STAB_MAX) && (code_i == r_cand) && (r_cand != r_acc_code);
   assign w_tagged   = (r_cand[CODE_W-1 -: 8] == TAG);
   assign w_lo       = r_cand[7:0];
   assign w_is_arm   = (w_lo == ARM_IDX);
   assign w_is_pass  = (w_lo == PASS_IDX);
   assign w_is_end   = (w_lo == (ARM_IDX + 8'd1 + {4'd0, r_seg}));
   assign w_lat_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
   assign w_active   = (r_state == S_ARMED) || (r_state == S_WAIT_PASS);
   assign w_timeout  = w_active && (r_tcnt == TO_LAST);

   // Glitch filter; acc_code starts at 0 so an all-zero bus is never accepted.
   always_ff @(posedge wb_clk_i) begin
      if (w_clear) begin
         r_cand     <= '0;
         r_stab     <= '0;
         r_acc_code <= '0;
         r_acc      <= 1'b0;
      end else begin
         r_acc <= w_acc;
         if (code_i != r_cand) begin
            r_cand <= code_i;
            r_stab <= '0;
         end else if (r_stab != STAB_MAX) begin
            r_stab <= r_stab + 1'b1;
         end
         if (w_acc) begin
            r_acc_code <= r_cand;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_clear) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_tcnt      <= '0;
         r_lat_valid <= '0;
         r_seg       <= '0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_err       <= 2'd0;
         for (int unsigned i = 0; i < N_SEG; i++) begin
            r_lat[i] <= '0;
         end
      end else begin
         if ((r_state == S_ARMED) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_active) begin
            r_tcnt <= r_tcnt + 1'b1;
         end
         // Timeout outranks a code accepted on the same edge.
         if (w_timeout) begin
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
            r_err   <= 2'd1;
         end else if (w_acc && w_tagged) begin
            case (r_state)
               S_IDLE: begin
                  if (w_is_arm) begin
                     r_state <= S_ARMED;
                     r_cnt   <= '0;
                     r_tcnt  <= '0;
                  end
               end
               S_ARMED: begin
                  if (w_is_end) begin
                     r_lat[r_seg[IDX_W-1:0]]       <= w_lat_next;
                     r_lat_valid[r_seg[IDX_W-1:0]] <= 1'b1;
                     r_cnt                         <= '0;
                     r_seg                         <= r_seg + 4'd1;
                     if (r_seg == SEG_LAST) begin
                        r_state <= S_WAIT_PASS;
                     end
                  end else begin
                     r_state <= S_FAIL;
                     r_fail  <= 1'b1;
                     r_err   <= w_is_pass ? 2'd3 : 2'd2;
                  end
               end
               S_WAIT_PASS: begin
                  if (w_is_pass) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FAIL;
                     r_fail  <= 1'b1;
                     r_err   <= 2'd2;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_clear) begin
         r_rd_lat <= '0;
      end else if ({1'b0, rd_idx_i} < NSEG_5) begin
         r_rd_lat <= r_lat[rd_idx_i[IDX_W-1:0]];
      end else begin
         r_rd_lat <= '0;
      end
   end

   assign rd_lat_o    = r_rd_lat;
   assign lat_valid_o = r_lat_valid;
   assign seg_o       = r_seg;
   assign acc_o       = r_acc;
   assign done_o      = r_done;
   assign fail_o      = r_fail;
   assign err_o       = r_err;

endmodule

// File: tb/tb_ckpt_latency_monitor.sv
// Directed bench for ckpt_latency_monitor with a timestamp-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_ckpt_latency_monitor;

   localparam int unsigned TO = 500;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        clr    = 1'b0;
   logic [15:0] code   = 16'h0000;
   logic [3:0]  rd_idx = 4'd0;
   logic [7:0]  rd_lat;
   logic [2:0]  lat_valid;
   logic [3:0]  seg;
   logic        acc;
   logic        done;
   logic        fail;
   logic [1:0]  err;

   int unsigned checks  = 0;
   int unsigned errors  = 0;
   int unsigned acc_cnt = 0;

   // Reference model outputs (written only by the model process).
   int unsigned m_cyc = 0;
   logic        m_acc;
   int unsigned m_seg;
   logic [2:0]  m_valid;
   logic        m_done;
   logic        m_fail;
   logic [1:0]  m_err;
   logic [7:0]  m_rd;
   int unsigned m_lat [3];

   always #5 clk = ~clk;

   ckpt_latency_monitor #(
      .CODE_W      (16),
      .TAG         (8'hAB),
      .ARM_IDX     (8'h40),
      .PASS_IDX    (8'h51),
      .N_SEG       (3),
      .CNT_W       (8),
      .STABLE_CYC  (2),
      .TIMEOUT_CYC (TO)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .clr_i       (clr),
      .code_i      (code),
      .rd_idx_i    (rd_idx),
      .rd_lat_o    (rd_lat),
      .lat_valid_o (lat_valid),
      .seg_o       (seg),
      .acc_o       (acc),
      .done_o      (done),
      .fail_o      (fail),
      .err_o       (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a code is taken once it has been sampled on 3 consecutive edges
   // (first sight + STABLE_CYC) and differs from the last taken code.
   // Latencies are differences of acceptance timestamps, capped at 255.
   initial begin
      logic [15:0] last;
      logic [15:0] acc_code;
      int unsigned same;
      int unsigned arm_t;
      int unsigned mark_t;
      int unsigned d;
      int          phase;
      int          idx;
      bit          hit;
      forever begin
         @(posedge clk);
         m_cyc++;
         if (rst || clr) begin
            last = '0; acc_code = '0; same = 0; phase = 0; arm_t = 0; mark_t = 0;
            m_acc = 0; m_seg = 0; m_valid = '0; m_done = 0; m_fail = 0; m_err = 0; m_rd = '0;
            for (int i = 0; i < 3; i++) m_lat[i] = 0;
         end else begin
            idx  = int'(rd_idx);
            m_rd = (idx < 3) ? 8'(m_lat[idx]) : 8'd0;
            if (code == last) same++;
            else begin
               last = code;
               same = 1;
            end
            hit   = (same >= 3) && (code != acc_code);
            m_acc = hit;
            if ((phase == 1 || phase == 2) && (m_cyc - arm_t == TO)) begin
               phase = 4; m_fail = 1; m_err = 2'd1;
            end else if (hit && code[15:8] == 8'hAB) begin
               case (phase)
                  0: if (code[7:0] == 8'h40) begin
                        phase = 1; arm_t = m_cyc; mark_t = m_cyc;
                     end
                  1: if (code[7:0] == 8'h41 + 8'(m_seg)) begin
                        d = m_cyc - mark_t;
                        m_lat[m_seg]   = (d > 255) ? 255 : d;
                        m_valid[m_seg] = 1'b1;
                        mark_t = m_cyc;
                        m_seg++;
                        if (m_seg == 3) phase = 2;
                     end else begin
                        phase = 4; m_fail = 1;
                        m_err = (code[7:0] == 8'h51) ? 2'd3 : 2'd2;
                     end
                  2: if (code[7:0] == 8'h51) begin
                        phase = 3; m_done = 1;
                     end else begin
                        phase = 4; m_fail = 1; m_err = 2'd2;
                     end
                  default: ;
               endcase
            end
            if (hit) acc_code = code;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_cyc > 0) begin
            if (acc === 1'b1) acc_cnt++;
            chk("acc_o",       32'(acc),       32'(m_acc));
            chk("seg_o",       32'(seg),       m_seg);
            chk("lat_valid_o", 32'(lat_valid), 32'(m_valid));
            chk("done_o",      32'(done),      32'(m_done));
            chk("fail_o",      32'(fail),      32'(m_fail));
            chk("err_o",       32'(err),       32'(m_err));
            chk("rd_lat_o",    32'(rd_lat),    32'(m_rd));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; clr = 1'b0; code = 16'h0000; rd_idx = 4'd0;
      cycles(2);
      rst = 1'b0;
   endtask

   task automatic put(input logic [15:0] c, input int n);
      code = c;
      cycles(n);
   endtask

   initial begin
      int unsigned a0;
      int          fk;

      // Nominal run
      do_reset();
      chk("reset_rd", 32'(rd_lat), 0);
      chk("reset_flags", {28'd0, done, fail, err}, 0);
      put(16'hAB40, 100);
      put(16'hAB41, 250);
      put(16'hAB42, 40);
      put(16'hAB43, 10);
      put(16'hAB51, 10);
      chk("nom_valid", 32'(lat_valid), 7);
      chk("nom_done", 32'(done), 1);
      chk("nom_err", 32'(err), 0);
      chk("nom_seg", 32'(seg), 3);
      rd_idx = 4'd0; cycles(1); chk("nom_lat0", 32'(rd_lat), 100);
      rd_idx = 4'd1; cycles(1); chk("nom_lat1", 32'(rd_lat), 250);
      rd_idx = 4'd2; cycles(1); chk("nom_lat2", 32'(rd_lat), 40);

      // Glitch rejection, including a torn multi-bit update before arming
      do_reset();
      a0 = acc_cnt;
      put(16'hAB00, 1);
      put(16'hAB40, 10);
      chk("gl_arm_acc", acc_cnt - a0, 1);
      a0 = acc_cnt;
      put(16'hAB41, 1);
      put(16'hAB40, 10);
      chk("gl_acc", acc_cnt - a0, 0);
      chk("gl_seg", 32'(seg), 0);
      chk("gl_fail", 32'(fail), 0);

      // Out-of-order segment code
      do_reset();
      put(16'hAB40, 20);
      put(16'hAB42, 10);
      chk("ooo_fail", 32'(fail), 1);
      chk("ooo_err", 32'(err), 2);
      chk("ooo_seg", 32'(seg), 0);
      put(16'hAB41, 10);
      chk("ooo_err_hold", 32'(err), 2);
      chk("ooo_valid", 32'(lat_valid), 0);

      // Timeout, with a pass code accepted on the timeout edge
      do_reset();
      code = 16'hAB40;
      fk = 0;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         if (k == 500) code = 16'hAB51;
         if (fail === 1'b1 && fk == 0) fk = k;
      end
      chk("to_cycle", 32'(fk), 503);
      chk("to_err", 32'(err), 1);
      chk("to_done", 32'(done), 0);

      // Saturation then early pass
      do_reset();
      put(16'hAB40, 300);
      put(16'hAB41, 10);
      rd_idx = 4'd0; cycles(1);
      chk("sat_lat0", 32'(rd_lat), 255);
      chk("sat_seg", 32'(seg), 1);
      put(16'hAB51, 10);
      chk("early_err", 32'(err), 3);
      chk("early_fail", 32'(fail), 1);

      // Clear mid-run, then re-arm
      do_reset();
      put(16'hAB40, 20);
      put(16'hAB41, 30);
      chk("clr_pre_seg", 32'(seg), 1);
      clr = 1'b1; cycles(1); clr = 1'b0;
      chk("clr_outs", {12'd0, rd_lat, lat_valid, seg, acc, done, fail, err}, 0);
      cycles(5);
      put(16'hAB40, 10);
      put(16'hAB41, 10);
      rd_idx = 4'd0; cycles(1); chk("clr_lat0", 32'(rd_lat), 10);
      rd_idx = 4'd5; cycles(1); chk("rd_oob", 32'(rd_lat), 0);
      chk("clr_seg", 32'(seg), 1);
      chk("clr_fail", 32'(fail), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ckpt_latency_monitor.md
# ckpt_latency_monitor

Synthesizable monitor for the `mprj_io[31:16]` checkpoint bus in the user project area. Firmware writes tagged 16-bit codes: an arm code, then per-segment completion codes, then a pass code. The monitor runs in hardware, with no bench present, and does three things:
- debounces the code bus;
- measures the cycle latency of each segment into a register bank;
- flags timeout and sequencing errors.

It generalises bench-side checkpoint waiting and latency counting to N segments, configurable codes, glitch filtering and on-chip readout.

## Interface
Parameters:
- `CODE_W`, 16: checkpoint bus width.
- `TAG`, 8'hAB: required value of `code_i[CODE_W-1:CODE_W-8]`. Codes with any other upper byte are ignored.
- `ARM_IDX`, 8'h40: low byte of the arm code. Segment k (0-based) ends on low byte `ARM_IDX+1+k`.
- `PASS_IDX`, 8'h51: low byte of the pass code.
- `N_SEG`, 3: number of segments, 1..16.
- `CNT_W`, 32: latency counter width. Counters saturate.
- `STABLE_CYC`, 2: consecutive identical samples needed to accept a code. Minimum 1.
- `TIMEOUT_CYC`, 1000000: cycles from arm to pass before failure is declared.

Ports:
- `wb_clk_i`, in, 1: clock.
- `wb_rst_i`, in, 1: reset, synchronous, active-high.
- `clr_i`, in, 1: synchronous clear. Same effect as reset.
- `code_i`, in, CODE_W: checkpoint bus, synchronous to `wb_clk_i`.
- `rd_idx_i`, in, 4: latency readout index.
- `rd_lat_o`, out, CNT_W: latency of segment `rd_idx_i`, registered.
- `lat_valid_o`, out, N_SEG: bit k is set once segment k latency is captured.
- `seg_o`, out, 4: index of the segment currently being timed.
- `acc_o`, out, 1: one-cycle pulse when a new code is accepted.
- `done_o`, out, 1: sticky; pass code accepted after all segments.
- `fail_o`, out, 1: sticky; an error occurred.
- `err_o`, out, 2: error cause. 0 none, 1 timeout, 2 out-of-order, 3 early pass.

## Operation
- Filter:
  - Registers `cand` and `stab`. If `code_i != cand`, then `cand<=code_i` and `stab<=0`; otherwise `stab` counts up to `STABLE_CYC-1` and holds.
  - Acceptance occurs on the edge where `stab==STABLE_CYC-1`, the sample equals `cand`, and `cand != acc_code`. At that edge `acc_code<=cand` and `acc_o` pulses.
  - Re-writing the same code is never re-accepted.
  - Untagged accepted codes update `acc_code` and have no other effect.
- FSM states and transitions, all evaluated on accepted tagged codes:
  - IDLE → ARMED on the arm code. All other codes are ignored.
  - ARMED (timing segment `seg`):
    - End code for `seg`: `lat[seg]<=cnt+1` (saturating), set `lat_valid[seg]`, `cnt<=0`, `seg++`. After the last segment, go to WAIT_PASS.
    - Pass code: FAIL, err 3.
    - Any other tagged code (arm, wrong segment index, unknown index): FAIL, err 2.
  - WAIT_PASS: pass code → DONE. Any other tagged code → FAIL, err 2.
  - DONE, FAIL: absorbing until reset or `clr_i`.
- Segment counter `cnt`:
  - Cleared on the arm edge.
  - Increments every cycle in ARMED; saturates at all-ones.
  - Result: if consecutive codes are accepted D cycles apart, `lat = D`.
- Timeout counter:
  - Cleared on the arm edge; counts in ARMED and WAIT_PASS.
  - On the edge where it reaches `TIMEOUT_CYC`: FAIL, err 1.
  - If a code acceptance and the timeout fall on the same edge, the timeout wins.
- `fail_o`, `err_o`, `done_o` are sticky. Only the first error is recorded.
- Readout: `rd_lat_o <= (rd_idx_i < N_SEG) ? lat[rd_idx_i] : 0`. Readout is allowed in any state.

## Timing
- Reset and clear values:
  - All outputs 0; `lat[*]=0`; state IDLE.
  - `cand` and `acc_code` are set to 0, so code 0 is never accepted.
  - `clr_i` and `wb_rst_i` both take priority over every other event on the same edge.
- Acceptance latency: `STABLE_CYC` edges after `code_i` first presents a new stable value.
- Status visibility: state, `seg_o`, `lat_valid_o` and flags update on the acceptance edge itself.
- Glitches shorter than `STABLE_CYC` cycles are invisible, including a non-atomic multi-bit GPIO update.
- `rd_lat_o` has 1-cycle latency. If a capture and a read of the same index happen on the same edge, `rd_lat_o` returns the old value.

## Test plan
Directed cases, all with `N_SEG=3` and `STABLE_CYC=2`:
1. Nominal run: AB40, then AB41 100 cycles later, then AB42 +250, then AB43 +40, then AB51. Expect `lat`=100/250/40, `lat_valid_o=3'b111`, `done_o=1`, `err_o=0`.
2. Glitch rejection: 1-cycle AB41 pulse while armed, then back to AB40. Expect no `acc_o`, `seg_o` stays 0, no error.
3. Out-of-order: AB40 then AB42. Expect `fail_o=1`, `err_o=2`, `seg_o=0`. A later AB41 has no effect.
4. Timeout: `TIMEOUT_CYC=500`, AB40 held. Expect `fail_o` exactly 500 cycles after the arm edge, `err_o=1`. Also an AB51 accepted on that same edge: expect `err_o` stays 1.
5. Early pass and saturation: `CNT_W=8`, AB40 then AB41 after 300 cycles. Expect `lat[0]=255`. Then AB51. Expect `err_o=3`.
6. Reset/clear mid-run: assert `clr_i` in segment 1. Expect all outputs 0 and state IDLE. Then re-arm with AB40 → AB41 after 10 cycles. Expect `lat[0]=10`. Readout with `rd_idx_i=5` returns 0.
